mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns the D-stage access into a data-bus request,
// waits for dack (stalling upstream), and loads the E-stage writeback registers.
module mem_access_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic [4:0]            RdD,
  input  logic [2:0]            Funct3D,
  input  logic [DATA_WIDTH-1:0] ALUResultD,
  input  logic [DATA_WIDTH-1:0] MemWriteDataD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  dreq,
  output logic                  dwe,
  output logic [DATA_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic [3:0]            dbe,
  input  logic                  dack,
  input  logic [DATA_WIDTH-1:0] drdata,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic [4:0]            RdE,
  output logic [DATA_WIDTH-1:0] ALUResultE,
  output logic [DATA_WIDTH-1:0] ReadDataE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [DATA_WIDTH-1:0] ForwardALUResultDH,
  output logic                  StallM,
  output logic                  MisalignE
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;

  logic                  regwrite_e_q, regwrite_e_d, misalign_e_q, misalign_e_d;
  logic [1:0]            resultsrc_e_q, resultsrc_e_d;
  logic [4:0]            rd_e_q, rd_e_d;
  logic [DATA_WIDTH-1:0] alu_e_q, alu_e_d, rdata_e_q, rdata_e_d, pc4_e_q, pc4_e_d;

  logic                  is_load, is_access, misalign, bus_access, complete;
  logic [1:0]            off;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c, shifted, load_data;

  assign off        = ALUResultD[1:0];
  assign is_load    = (ResultSrcD == 2'b01) && !MemWriteD;
  assign is_access  = is_load || MemWriteD;
  assign bus_access = is_access && !misalign;
  assign shifted    = drdata >> {off, 3'b000};

  // Access size comes from Funct3[1:0]: 00 byte, 01 half, 10 word.
  always_comb begin
    misalign = 1'b0;
    be_c     = 4'b1111;
    wdata_c  = MemWriteDataD;
    case (Funct3D[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{MemWriteDataD[7:0]}};
      end
      2'b01: begin
        misalign = off[0];
        be_c     = 4'b0011 << off;
        wdata_c  = {2{MemWriteDataD[15:0]}};
      end
      2'b10: misalign = (off != 2'b00);
      default: ;
    endcase
    if (!MemWriteD) be_c = 4'b1111;
    if (!is_access) misalign = 1'b0;
  end

  always_comb begin
    case (Funct3D)
      3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  // Bus handshake: dreq stays high until the cycle dack is seen; that cycle completes.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    dreq     = 1'b0;
    dwe      = 1'b0;
    dbe      = 4'b0000;
    daddr    = '0;
    dwdata   = '0;
    StallM   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_access) begin
          dreq   = 1'b1;
          dwe    = MemWriteD;
          dbe    = be_c;
          daddr  = {ALUResultD[DATA_WIDTH-1:2], 2'b00};
          dwdata = wdata_c;
          if (dack) begin
            complete = 1'b1;
          end else begin
            StallM  = 1'b1;
            state_d = WAIT;
            addr_d  = {ALUResultD[DATA_WIDTH-1:2], 2'b00};
            wdata_d = wdata_c;
            be_d    = be_c;
            we_d    = MemWriteD;
          end
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        dreq   = 1'b1;
        dwe    = we_q;
        dbe    = be_q;
        daddr  = addr_q;
        dwdata = wdata_q;
        if (dack) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      dreq   = 1'b0;
      dwe    = 1'b0;
      dbe    = 4'b0000;
      StallM = 1'b0;
    end
  end

  // Stalled cycles push a bubble: no write enable, no misalign flag, data held.
  always_comb begin
    regwrite_e_d  = 1'b0;
    misalign_e_d  = 1'b0;
    resultsrc_e_d = resultsrc_e_q;
    rd_e_d        = rd_e_q;
    alu_e_d       = alu_e_q;
    rdata_e_d     = rdata_e_q;
    pc4_e_d       = pc4_e_q;
    if (complete) begin
      regwrite_e_d  = RegWriteD && !misalign;
      misalign_e_d  = misalign;
      resultsrc_e_d = ResultSrcD;
      rd_e_d        = RdD;
      alu_e_d       = ALUResultD;
      rdata_e_d     = (is_load && !misalign) ? load_data : '0;
      pc4_e_d       = PCPlus4D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= 4'b0000;
      we_q          <= 1'b0;
      regwrite_e_q  <= 1'b0;
      misalign_e_q  <= 1'b0;
      resultsrc_e_q <= 2'b00;
      rd_e_q        <= 5'd0;
      alu_e_q       <= '0;
      rdata_e_q     <= '0;
      pc4_e_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      we_q          <= we_d;
      regwrite_e_q  <= regwrite_e_d;
      misalign_e_q  <= misalign_e_d;
      resultsrc_e_q <= resultsrc_e_d;
      rd_e_q        <= rd_e_d;
      alu_e_q       <= alu_e_d;
      rdata_e_q     <= rdata_e_d;
      pc4_e_q       <= pc4_e_d;
    end
  end

  assign RegWriteE          = regwrite_e_q;
  assign MisalignE          = misalign_e_q;
  assign ResultSrcE         = resultsrc_e_q;
  assign RdE                = rd_e_q;
  assign ALUResultE         = alu_e_q;
  assign ReadDataE          = rdata_e_q;
  assign PCPlus4E           = pc4_e_q;
  assign ForwardALUResultDH = ALUResultD;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized loads/stores/non-accesses
// against a behavioural model of bus lanes, load extension and E-register writeback.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteD, MemWriteD;
  logic [1:0]  ResultSrcD;
  logic [4:0]  RdD;
  logic [2:0]  Funct3D;
  logic [31:0] ALUResultD, MemWriteDataD, PCPlus4D;
  logic        dreq, dwe, dack;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;
  logic        RegWriteE, StallM, MisalignE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  RdE;
  logic [31:0] ALUResultE, ReadDataE, PCPlus4E, ForwardALUResultDH;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .RdD(RdD),
    .Funct3D(Funct3D), .ALUResultD(ALUResultD), .MemWriteDataD(MemWriteDataD),
    .PCPlus4D(PCPlus4D), .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dbe(dbe), .dack(dack), .drdata(drdata), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .RdE(RdE), .ALUResultE(ALUResultE), .ReadDataE(ReadDataE),
    .PCPlus4E(PCPlus4E), .ForwardALUResultDH(ForwardALUResultDH), .StallM(StallM),
    .MisalignE(MisalignE)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model of the E-stage registers.
  logic        m_rw, m_mis;
  logic [1:0]  m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdata, m_pc4;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rw = 1'b0; m_mis = 1'b0; m_rs = 2'b00; m_rd = 5'd0;
    m_alu = '0; m_rdata = '0; m_pc4 = '0;
  endtask

  task automatic check_e();
    check("RegWriteE", 32'(RegWriteE), 32'(m_rw));
    check("MisalignE", 32'(MisalignE), 32'(m_mis));
    check("ResultSrcE", 32'(ResultSrcE), 32'(m_rs));
    check("RdE", 32'(RdE), 32'(m_rd));
    check("ALUResultE", ALUResultE, m_alu);
    check("ReadDataE", ReadDataE, m_rdata);
    check("PCPlus4E", PCPlus4E, m_pc4);
  endtask

  // Called just after a rising edge; holds the D inputs until the access completes.
  task automatic run_op(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc4,
                        input logic [31:0] rdata, input int delay);
    logic        is_load, access, mis, bus;
    logic [1:0]  off;
    logic [31:0] e_be, e_wd, e_rd, sh, msk;
    int          nb, w, n;
    RegWriteD = rw; MemWriteD = mw; ResultSrcD = rs; RdD = rd; Funct3D = f3;
    ALUResultD = addr; MemWriteDataD = wd; PCPlus4D = pc4;
    is_load = (rs == 2'b01) && !mw;
    access  = is_load || mw;
    off     = addr[1:0];
    mis     = 1'b0;
    if (access && (f3 == 3'd1 || f3 == 3'd5) && addr[0]) mis = 1'b1;
    if (access && f3 == 3'd2 && off != 2'd0) mis = 1'b1;
    bus = access && !mis;
    nb  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    e_be = mw ? (((32'd1 << nb) - 32'd1) << off) : 32'hF;
    e_wd = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
           (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    e_rd = '0;
    if (is_load && !mis) begin
      sh = rdata >> (8 * off);
      case (f3)
        3'd0, 3'd4: w = 8;
        3'd1, 3'd5: w = 16;
        3'd2:       w = 32;
        default:    w = 0;
      endcase
      if (w == 32) e_rd = sh;
      else if (w > 0) begin
        msk  = (32'd1 << w) - 32'd1;
        e_rd = sh & msk;
        if (f3 < 3'd4 && e_rd >= (32'd1 << (w - 1))) e_rd = e_rd - (32'd1 << w);
      end
    end
    exp_q.push_back(e_rd);
    n = bus ? delay : 0;
    for (int c = 0; c <= n; c++) begin
      if (bus) begin
        dack   = (c == n);
        drdata = (c == n) ? rdata : $urandom;
      end else begin
        dack   = 1'($urandom_range(0, 1));
        drdata = $urandom;
      end
      @(negedge clk);
      check("dreq", 32'(dreq), 32'(bus));
      check("StallM", 32'(StallM), 32'(bus && c < n));
      check("ForwardALUResultDH", ForwardALUResultDH, addr);
      if (bus) begin
        check("daddr", daddr, {addr[31:2], 2'b00});
        check("dwe", 32'(dwe), 32'(mw));
        check("dbe", 32'(dbe), e_be);
        if (mw) check("dwdata", dwdata, e_wd);
      end else begin
        check("dwe_idle", 32'(dwe), 32'd0);
        check("dbe_idle", 32'(dbe), 32'd0);
      end
      @(posedge clk);
      #1;
      if (bus && c < n) begin
        m_rw = 1'b0; m_mis = 1'b0;
      end else begin
        m_rw = rw && !mis; m_mis = mis; m_rs = rs; m_rd = rd;
        m_alu = addr; m_pc4 = pc4; m_rdata = exp_q.pop_front();
      end
      check_e();
    end
  endtask

  initial begin
    logic        rw, mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind;
    rst_n = 1'b0;
    RegWriteD = 1'b0; MemWriteD = 1'b0; ResultSrcD = 2'b00; RdD = 5'd0; Funct3D = 3'd0;
    ALUResultD = '0; MemWriteDataD = '0; PCPlus4D = '0; dack = 1'b0; drdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dreq", 32'(dreq), 32'd0);
    check("rst_StallM", 32'(StallM), 32'd0);
    check_e();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LB at byte 3, sign-extended.
    run_op(1'b1, 1'b0, 2'b01, 5'd5, 3'd0, 32'h103, 32'h0, 32'h44, 32'h80112233, 0);
    // SH at halfword 2.
    run_op(1'b0, 1'b1, 2'b00, 5'd0, 3'd1, 32'h102, 32'h0000BEEF, 32'h48, 32'h0, 0);
    // LW with a 3-cycle wait.
    run_op(1'b1, 1'b0, 2'b01, 5'd7, 3'd2, 32'h200, 32'h0, 32'h4C, 32'hCAFEF00D, 3);
    // Misaligned LW.
    run_op(1'b1, 1'b0, 2'b01, 5'd8, 3'd2, 32'h101, 32'h0, 32'h50, 32'h12345678, 2);
    // Non-access writeback.
    run_op(1'b1, 1'b0, 2'b00, 5'd9, 3'd0, 32'h1234, 32'h0, 32'h54, 32'h0, 0);

    // Reset asserted while waiting for dack.
    RegWriteD = 1'b1; MemWriteD = 1'b0; ResultSrcD = 2'b01; RdD = 5'd10; Funct3D = 3'd2;
    ALUResultD = 32'h300; PCPlus4D = 32'h58; dack = 1'b0;
    @(negedge clk);
    check("wait_StallM", 32'(StallM), 32'd1);
    @(posedge clk);
    #1;
    m_rw = 1'b0; m_mis = 1'b0;
    check_e();
    @(negedge clk);
    check("wait_dreq", 32'(dreq), 32'd1);
    #1;
    rst_n = 1'b0;
    RegWriteD = 1'b0; ResultSrcD = 2'b00; dack = 1'b1;
    #1;
    check("rst_mid_dreq", 32'(dreq), 32'd0);
    check("rst_mid_StallM", 32'(StallM), 32'd0);
    model_reset();
    check_e();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(1'b0, 1'b0, 2'b00, 5'd11, 3'd2, 32'h300, 32'h0, 32'h5C, 32'h0, 0);
    run_op(1'b1, 1'b0, 2'b01, 5'd12, 3'd4, 32'h402, 32'h0, 32'h60, 32'h00C30000, 1);

    repeat (300) begin
      kind = $urandom_range(0, 2);
      addr = $urandom;
      rw   = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        mw = 1'b0; rs = 2'b01; f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd3 || f3 >= 3'd6) addr[1:0] = 2'b00;
      end else if (kind == 1) begin
        mw = 1'b1; rs = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 2));
      end else begin
        mw = 1'b0; rs = 2'($urandom_range(0, 2)); f3 = 3'($urandom_range(0, 7));
        if (rs == 2'b01) rs = 2'b11;
      end
      run_op(rw, mw, rs, 5'($urandom_range(0, 31)), f3, addr, $urandom, $urandom,
             $urandom, $urandom_range(0, 3));
    end

    if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
